// File: rtl/mips_pkg.sv
// Shared types for the MIPS load/store path: memory op codes, LSU FSM states
// and the small decode helpers used by both Control and the LSU.
package mips_pkg;

  typedef enum logic [2:0] {
    LW = 3'd0,
    LH = 3'd1,
    LB = 3'd2,
    SW = 3'd3,
    SH = 3'd4,
    SB = 3'd5
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } lsu_state_e;

  localparam int unsigned READ_LAT_MAX = 7;
  localparam int unsigned CNT_W        = $clog2(READ_LAT_MAX + 1);

  // Unused encodings behave as a word load.
  function automatic mem_op_e decodeOp(input logic [2:0] raw);
    mem_op_e op;
    case (raw)
      3'd1:    op = LH;
      3'd2:    op = LB;
      3'd3:    op = SW;
      3'd4:    op = SH;
      3'd5:    op = SB;
      default: op = LW;
    endcase
    return op;
  endfunction

  function automatic logic isMisaligned(input mem_op_e op, input logic [1:0] off);
    logic mis;
    case (op)
      LW, SW:  mis = (off != 2'b00);
      LH, SH:  mis = off[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bundle from Control plus the data-memory port of the LSU.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        err;
  logic [31:0] ld_data;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, done, err, ld_data, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, done, err, ld_data, mem_addr, mem_wr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: load extraction with sign extension, and merging
// a byte/halfword store into the previously read word.
module lsu_lane_align
  import mips_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldData_o,
  output logic [31:0] stWord_o
);

  logic [4:0]  byteShift;
  logic [4:0]  halfShift;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Offset 0 is the most significant lane, so shift distance counts down from the top.
  assign byteShift = {~off_i, 3'b000};
  assign halfShift = {~off_i[1], 4'b0000};
  assign byteLane  = 8'(word_i >> byteShift);
  assign halfLane  = 16'(word_i >> halfShift);

  always_comb begin
    ldData_o = word_i;
    stWord_o = wdata_i;
    case (op_i)
      LB: ldData_o = {{24{byteLane[7]}}, byteLane};
      LH: ldData_o = {{16{halfLane[15]}}, halfLane};
      SB: stWord_o = (word_i & ~(32'h0000_00FF << byteShift)) |
                     ({24'b0, wdata_i[7:0]} << byteShift);
      SH: stWord_o = (word_i & ~(32'h0000_FFFF << halfShift)) |
                     ({16'b0, wdata_i[15:0]} << halfShift);
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: word memory port with fixed read latency,
// misalignment detection, and read-modify-write for byte/halfword stores.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int unsigned READ_LAT = 2
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  load_store_unit_if.slave bus
);

  lsu_state_e       state_q, state_d;
  mem_op_e          op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      ldData_q, ldData_d;

  mem_op_e     reqOp;
  logic [31:0] alignWord;
  logic [31:0] alignLd;
  logic [31:0] alignSt;

  assign reqOp     = decodeOp(bus.req_op);
  assign alignWord = (state_q == READ) ? bus.mem_rdata : word_q;

  lsu_lane_align u_align (
    .op_i     (op_q),
    .off_i    (addr_q[1:0]),
    .word_i   (alignWord),
    .wdata_i  (wdata_q),
    .ldData_o (alignLd),
    .stWord_o (alignSt)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      op_q     <= LW;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ldData_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ldData_q <= ldData_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ldData_d = ldData_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = reqOp;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (isMisaligned(reqOp, bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (reqOp == SW) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        // The memory word is only guaranteed valid in the final counted cycle.
        if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          cnt_d  = '0;
          word_d = bus.mem_rdata;
          if (op_q == SH || op_q == SB) begin
            state_d = WRITE;
          end else begin
            ldData_d = alignLd;
            state_d  = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == DONE) && err_q;
  assign bus.mem_wr    = (state_q == WRITE);
  assign bus.mem_addr  = (state_q == READ || state_q == WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign bus.mem_wdata = (state_q == WRITE) ? alignSt : '0;
  assign bus.ld_data   = ldData_q;

endmodule
